// File: rtl/load_store_unit.sv
// Byte-serial load/store initiator: turns one RISC-V LB/LH/LW/LBU/LHU/SB/SH/SW
// request into single-byte accesses on the byte-wide memory port.
module load_store_unit (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] base_address,
    input  logic [31:0] store_data,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [31:0] load_data,
    output logic [31:0] mem_address,
    output logic [7:0]  mem_write_data,
    output logic        mem_write_enable,
    input  logic [7:0]  mem_read_data
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_s;
    logic [1:0]  idx_r;
    logic [31:0] addr_r;
    logic [31:0] data_r;
    logic        is_store_r;
    logic [2:0]  funct3_r;
    logic        error_r;
    logic [31:0] buf_r;
    logic [31:0] buf_s;
    logic [31:0] load_data_r;
    logic        illegal_s;
    logic        last_s;

    // Index of the final byte for a width code: B/BU -> 0, H/HU -> 1, W -> 3.
    function automatic logic [1:0] last_index(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   last_index = 2'd0;
            2'b01:   last_index = 2'd1;
            default: last_index = 2'd3;
        endcase
    endfunction

    function automatic logic [31:0] extend_load(input logic [2:0] f3, input logic [31:0] raw);
        case (f3)
            3'b000:  extend_load = {{24{raw[7]}}, raw[7:0]};
            3'b100:  extend_load = {24'h00_0000, raw[7:0]};
            3'b001:  extend_load = {{16{raw[15]}}, raw[15:0]};
            3'b101:  extend_load = {16'h0000, raw[15:0]};
            default: extend_load = raw;
        endcase
    endfunction

    // Request legality and last-byte detection.
    always_comb begin
        illegal_s = (funct3 == 3'b011) || (funct3[2:1] == 2'b11) || (is_store && funct3[2]);
        last_s    = (idx_r == last_index(funct3_r));
    end

    // Load buffer including the byte arriving this cycle, so the extension at
    // the DONE-entry edge already sees the final byte.
    always_comb begin
        buf_s = buf_r;
        if ((state_r == ST_ACCESS) && !is_store_r) begin
            buf_s[{idx_r, 3'b000} +: 8] = mem_read_data;
        end else begin
            buf_s = buf_r;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s = illegal_s ? ST_DONE : ST_ACCESS;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (last_s) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_ACCESS;
                end
            end
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // State, request latches, byte index, load buffer and result register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r     <= ST_IDLE;
            idx_r       <= 2'd0;
            addr_r      <= 32'h0000_0000;
            data_r      <= 32'h0000_0000;
            is_store_r  <= 1'b0;
            funct3_r    <= 3'b000;
            error_r     <= 1'b0;
            buf_r       <= 32'h0000_0000;
            load_data_r <= 32'h0000_0000;
        end else begin
            state_r <= state_s;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        addr_r     <= base_address;
                        data_r     <= store_data;
                        is_store_r <= is_store;
                        funct3_r   <= funct3;
                        idx_r      <= 2'd0;
                        buf_r      <= 32'h0000_0000;
                        error_r    <= illegal_s;
                        if (illegal_s) begin
                            load_data_r <= 32'h0000_0000;
                        end
                    end
                end
                ST_ACCESS: begin
                    idx_r <= idx_r + 2'd1;
                    buf_r <= buf_s;
                    if (last_s) begin
                        load_data_r <= is_store_r ? 32'h0000_0000 : extend_load(funct3_r, buf_s);
                    end
                end
                ST_DONE: begin
                    idx_r <= 2'd0;
                end
                default: begin
                    idx_r <= 2'd0;
                end
            endcase
        end
    end

    // Memory port: address wraps modulo 2^32; write data only driven for stores in ACCESS.
    always_comb begin
        mem_address    = addr_r;
        mem_write_data = 8'h00;
        if (state_r == ST_ACCESS) begin
            mem_address = addr_r + {30'd0, idx_r};
            if (is_store_r) begin
                mem_write_data = data_r[{idx_r, 3'b000} +: 8];
            end else begin
                mem_write_data = 8'h00;
            end
        end else begin
            mem_address = addr_r;
        end
    end

    // reset_n gates the strobe directly so no byte commits on a reset edge.
    assign mem_write_enable = reset_n && (state_r == ST_ACCESS) && is_store_r && !error_r;
    assign busy             = (state_r != ST_IDLE);
    assign done             = (state_r == ST_DONE);
    assign error            = (state_r == ST_DONE) && error_r;
    assign load_data        = load_data_r;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: byte memory model, event monitor and
// expectation queues popped as the DUT completes each request.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        is_store = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] base_address = 32'h0000_0000;
    logic [31:0] store_data = 32'h0000_0000;
    logic        busy;
    logic        done;
    logic        error;
    logic [31:0] load_data;
    logic [31:0] mem_address;
    logic [7:0]  mem_write_data;
    logic        mem_write_enable;
    logic [7:0]  mem_read_data;

    load_store_unit dut (
        .clk(clk), .reset_n(reset_n), .start(start), .is_store(is_store),
        .funct3(funct3), .base_address(base_address), .store_data(store_data),
        .busy(busy), .done(done), .error(error), .load_data(load_data),
        .mem_address(mem_address), .mem_write_data(mem_write_data),
        .mem_write_enable(mem_write_enable), .mem_read_data(mem_read_data)
    );

    always #5 clk = ~clk;

    // 64-byte memory aliased on address bits [5:0]
    logic [7:0] mem [64];
    logic       poke_en = 1'b0;
    logic [5:0] poke_addr = 6'd0;
    logic [7:0] poke_data = 8'h00;
    assign mem_read_data = mem[mem_address[5:0]];

    always @(posedge clk) begin
        if (poke_en) mem[poke_addr] <= poke_data;
        if (mem_write_enable) mem[mem_address[5:0]] <= mem_write_data;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: log observed DUT events at the falling edge
    logic [31:0] wr_addr_q[$];
    logic [7:0]  wr_data_q[$];
    logic [31:0] acc_addr_q[$];
    int          acc_cyc_q[$];
    logic [31:0] dn_data_q[$];
    logic        dn_err_q[$];
    int          dn_cyc_q[$];

    always @(negedge clk) begin
        if (mem_write_enable) begin
            wr_addr_q.push_back(mem_address);
            wr_data_q.push_back(mem_write_data);
        end
        if (busy && !done) begin
            acc_addr_q.push_back(mem_address);
            acc_cyc_q.push_back(cyc);
        end
        if (done) begin
            dn_data_q.push_back(load_data);
            dn_err_q.push_back(error);
            dn_cyc_q.push_back(cyc);
        end
    end

    // Expectation queues
    logic [31:0] exp_ld_q[$];
    logic        exp_err_q[$];
    int          exp_lat_q[$];
    logic [31:0] exp_wa_q[$];
    logic [7:0]  exp_wd_q[$];

    int tests_run = 0;
    int tests_failed = 0;

    task automatic poke(input logic [5:0] a, input logic [7:0] d);
        @(negedge clk); #1;
        poke_en = 1'b1; poke_addr = a; poke_data = d;
        @(posedge clk); #1;
        poke_en = 1'b0;
    endtask

    // Drive one start pulse; t0 is the cycle index just before the accepting edge.
    task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] d, output int t0);
        @(negedge clk); #1;
        start = 1'b1; is_store = st; funct3 = f3; base_address = a; store_data = d;
        t0 = cyc;
        @(negedge clk); #1;
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++;
        if ({busy, done, error, mem_write_enable, load_data, mem_address, mem_write_data} !== 76'd0) begin
            tests_failed++;
            $display("FAIL reset_state: busy=%b done=%b error=%b we=%b ld=%h addr=%h wd=%h, required all 0",
                     busy, done, error, mem_write_enable, load_data, mem_address, mem_write_data);
        end
        #1 reset_n = 1'b1;
    endtask

    task automatic test_lw();
        int t0, dn0, ac0, n;
        logic bad;
        logic [31:0] e_ld; logic e_err; int e_lat;
        poke(6'd0, 8'h78); poke(6'd1, 8'h56); poke(6'd2, 8'h34); poke(6'd3, 8'h12);
        dn0 = dn_data_q.size(); ac0 = acc_addr_q.size();
        exp_ld_q.push_back(32'h1234_5678); exp_err_q.push_back(1'b0); exp_lat_q.push_back(5);
        issue(1'b0, 3'b010, 32'h0000_1000, 32'h0, t0);
        repeat (6) @(negedge clk);
        tests_run++;
        n = acc_addr_q.size() - ac0;
        bad = (n != 4);
        for (int k = 0; k < 4; k++) begin
            if (!bad && (acc_addr_q[ac0 + k] !== 32'h0000_1000 + 32'(k) || acc_cyc_q[ac0 + k] != t0 + 1 + k)) bad = 1'b1;
        end
        if (bad) begin
            tests_failed++;
            $display("FAIL lw_addr: %0d access cycles, first address %h, required 4 cycles 00001000..00001003 in cycles 1-4",
                     n, (n > 0) ? acc_addr_q[ac0] : 32'h0);
        end
        tests_run++;
        e_ld = exp_ld_q.pop_front(); e_err = exp_err_q.pop_front(); e_lat = exp_lat_q.pop_front();
        if (dn_data_q.size() != dn0 + 1) begin
            tests_failed++;
            $display("FAIL lw_done: %0d done pulses, required 1", dn_data_q.size() - dn0);
        end else if (dn_data_q[dn0] !== e_ld || dn_err_q[dn0] !== e_err || dn_cyc_q[dn0] - t0 != e_lat) begin
            tests_failed++;
            $display("FAIL lw_result: ld=%h err=%b lat=%0d, required ld=%h err=%b lat=%0d",
                     dn_data_q[dn0], dn_err_q[dn0], dn_cyc_q[dn0] - t0, e_ld, e_err, e_lat);
        end
    endtask

    task automatic test_lb_lbu();
        int t0, dn0;
        logic [31:0] e_ld; logic e_err; int e_lat;
        logic [2:0] f3s [2] = '{3'b000, 3'b100};
        poke(6'd3, 8'h80);
        for (int i = 0; i < 2; i++) begin
            dn0 = dn_data_q.size();
            exp_ld_q.push_back((i == 0) ? 32'hFFFF_FF80 : 32'h0000_0080);
            exp_err_q.push_back(1'b0); exp_lat_q.push_back(2);
            issue(1'b0, f3s[i], 32'h0000_1003, 32'h0, t0);
            repeat (3) @(negedge clk);
            tests_run++;
            e_ld = exp_ld_q.pop_front(); e_err = exp_err_q.pop_front(); e_lat = exp_lat_q.pop_front();
            if (dn_data_q.size() != dn0 + 1) begin
                tests_failed++;
                $display("FAIL lb%0d_done: %0d done pulses, required 1", i, dn_data_q.size() - dn0);
            end else if (dn_data_q[dn0] !== e_ld || dn_err_q[dn0] !== e_err || dn_cyc_q[dn0] - t0 != e_lat) begin
                tests_failed++;
                $display("FAIL lb%0d_result: ld=%h err=%b lat=%0d, required ld=%h err=%b lat=%0d", i,
                         dn_data_q[dn0], dn_err_q[dn0], dn_cyc_q[dn0] - t0, e_ld, e_err, e_lat);
            end
        end
    endtask

    task automatic test_sh_readback();
        int t0, dn0, wr0, n;
        logic bad;
        logic [31:0] e_ld, ea; logic [7:0] ed; logic e_err; int e_lat;
        dn0 = dn_data_q.size(); wr0 = wr_addr_q.size();
        exp_wa_q.push_back(32'h0000_1001); exp_wd_q.push_back(8'hDD);
        exp_wa_q.push_back(32'h0000_1002); exp_wd_q.push_back(8'hCC);
        exp_ld_q.push_back(32'h0); exp_err_q.push_back(1'b0); exp_lat_q.push_back(3);
        issue(1'b1, 3'b001, 32'h0000_1001, 32'hAABB_CCDD, t0);
        repeat (4) @(negedge clk);
        tests_run++;
        n = wr_addr_q.size() - wr0;
        bad = 1'b0;
        if (n != exp_wa_q.size()) begin
            bad = 1'b1;
            $display("FAIL sh_writes: %0d write cycles, required %0d", n, exp_wa_q.size());
            exp_wa_q.delete(); exp_wd_q.delete();
        end else begin
            for (int k = 0; k < n; k++) begin
                ea = exp_wa_q.pop_front(); ed = exp_wd_q.pop_front();
                if (wr_addr_q[wr0 + k] !== ea || wr_data_q[wr0 + k] !== ed) begin
                    bad = 1'b1;
                    $display("FAIL sh_write%0d: %h<=%h, required %h<=%h", k, wr_addr_q[wr0 + k], wr_data_q[wr0 + k], ea, ed);
                end
            end
        end
        if (bad) tests_failed++;
        tests_run++;
        e_ld = exp_ld_q.pop_front(); e_err = exp_err_q.pop_front(); e_lat = exp_lat_q.pop_front();
        if (dn_data_q.size() != dn0 + 1 || dn_data_q[dn0] !== e_ld || dn_err_q[dn0] !== e_err || dn_cyc_q[dn0] - t0 != e_lat) begin
            tests_failed++;
            $display("FAIL sh_done: %0d pulses, required 1 with ld=%h err=%b lat=%0d", dn_data_q.size() - dn0, e_ld, e_err, e_lat);
        end
        dn0 = dn_data_q.size();
        exp_ld_q.push_back(32'h0000_CCDD); exp_err_q.push_back(1'b0); exp_lat_q.push_back(3);
        issue(1'b0, 3'b101, 32'h0000_1001, 32'h0, t0);
        repeat (4) @(negedge clk);
        tests_run++;
        e_ld = exp_ld_q.pop_front(); e_err = exp_err_q.pop_front(); e_lat = exp_lat_q.pop_front();
        if (dn_data_q.size() != dn0 + 1) begin
            tests_failed++;
            $display("FAIL lhu_done: %0d done pulses, required 1", dn_data_q.size() - dn0);
        end else if (dn_data_q[dn0] !== e_ld || dn_err_q[dn0] !== e_err || dn_cyc_q[dn0] - t0 != e_lat) begin
            tests_failed++;
            $display("FAIL lhu_result: ld=%h err=%b lat=%0d, required ld=%h err=%b lat=%0d",
                     dn_data_q[dn0], dn_err_q[dn0], dn_cyc_q[dn0] - t0, e_ld, e_err, e_lat);
        end
    endtask

    task automatic test_illegal();
        int t0, dn0, wr0;
        logic [31:0] e_ld; logic e_err; int e_lat;
        logic       sts [2] = '{1'b0, 1'b1};
        logic [2:0] f3s [2] = '{3'b011, 3'b100};
        for (int i = 0; i < 2; i++) begin
            dn0 = dn_data_q.size(); wr0 = wr_addr_q.size();
            exp_ld_q.push_back(32'h0); exp_err_q.push_back(1'b1); exp_lat_q.push_back(1);
            issue(sts[i], f3s[i], 32'h0000_1000, 32'hDEAD_BEEF, t0);
            repeat (3) @(negedge clk);
            tests_run++;
            e_ld = exp_ld_q.pop_front(); e_err = exp_err_q.pop_front(); e_lat = exp_lat_q.pop_front();
            if (dn_data_q.size() != dn0 + 1) begin
                tests_failed++;
                $display("FAIL illegal%0d_done: %0d done pulses, required 1", i, dn_data_q.size() - dn0);
            end else if (dn_data_q[dn0] !== e_ld || dn_err_q[dn0] !== e_err || dn_cyc_q[dn0] - t0 != e_lat) begin
                tests_failed++;
                $display("FAIL illegal%0d_result: ld=%h err=%b lat=%0d, required ld=%h err=%b lat=%0d", i,
                         dn_data_q[dn0], dn_err_q[dn0], dn_cyc_q[dn0] - t0, e_ld, e_err, e_lat);
            end
            tests_run++;
            if (wr_addr_q.size() != wr0) begin
                tests_failed++;
                $display("FAIL illegal%0d_writes: %0d write cycles, required 0", i, wr_addr_q.size() - wr0);
            end
        end
    endtask

    task automatic test_reset_mid_sw();
        int t0, dn0, wr0, n;
        logic bad;
        logic [31:0] e_ld, ea; logic [7:0] ed; logic e_err; int e_lat;
        dn0 = dn_data_q.size(); wr0 = wr_addr_q.size();
        exp_wa_q.push_back(32'h0000_1000); exp_wd_q.push_back(8'h44);
        exp_wa_q.push_back(32'h0000_1001); exp_wd_q.push_back(8'h33);
        issue(1'b1, 3'b010, 32'h0000_1000, 32'h1122_3344, t0);
        @(posedge clk);
        @(posedge clk); #1;
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(negedge clk);
        tests_run++;
        if ({busy, done, error, mem_write_enable, load_data, mem_address, mem_write_data} !== 76'd0) begin
            tests_failed++;
            $display("FAIL rst_mid_outputs: busy=%b done=%b error=%b we=%b ld=%h addr=%h wd=%h, required all 0",
                     busy, done, error, mem_write_enable, load_data, mem_address, mem_write_data);
        end
        repeat (3) @(negedge clk);
        tests_run++;
        n = wr_addr_q.size() - wr0;
        bad = 1'b0;
        if (n != exp_wa_q.size()) begin
            bad = 1'b1;
            $display("FAIL rst_mid_writes: %0d write cycles, required %0d", n, exp_wa_q.size());
            exp_wa_q.delete(); exp_wd_q.delete();
        end else begin
            for (int k = 0; k < n; k++) begin
                ea = exp_wa_q.pop_front(); ed = exp_wd_q.pop_front();
                if (wr_addr_q[wr0 + k] !== ea || wr_data_q[wr0 + k] !== ed) begin
                    bad = 1'b1;
                    $display("FAIL rst_mid_write%0d: %h<=%h, required %h<=%h", k, wr_addr_q[wr0 + k], wr_data_q[wr0 + k], ea, ed);
                end
            end
        end
        if (bad) tests_failed++;
        tests_run++;
        if (dn_data_q.size() != dn0 || mem[2] !== 8'hCC) begin
            tests_failed++;
            $display("FAIL rst_mid_aborted: %0d done pulses, mem[1002]=%h, required 0 pulses and CC", dn_data_q.size() - dn0, mem[2]);
        end
        // Memory now holds 44 33 CC 80 at 0x1000..0x1003
        dn0 = dn_data_q.size();
        exp_ld_q.push_back(32'h80CC_3344); exp_err_q.push_back(1'b0); exp_lat_q.push_back(5);
        issue(1'b0, 3'b010, 32'h0000_1000, 32'h0, t0);
        repeat (6) @(negedge clk);
        tests_run++;
        e_ld = exp_ld_q.pop_front(); e_err = exp_err_q.pop_front(); e_lat = exp_lat_q.pop_front();
        if (dn_data_q.size() != dn0 + 1) begin
            tests_failed++;
            $display("FAIL post_rst_lw_done: %0d done pulses, required 1", dn_data_q.size() - dn0);
        end else if (dn_data_q[dn0] !== e_ld || dn_err_q[dn0] !== e_err || dn_cyc_q[dn0] - t0 != e_lat) begin
            tests_failed++;
            $display("FAIL post_rst_lw_result: ld=%h err=%b lat=%0d, required ld=%h err=%b lat=%0d",
                     dn_data_q[dn0], dn_err_q[dn0], dn_cyc_q[dn0] - t0, e_ld, e_err, e_lat);
        end
    endtask

    task automatic test_wrap_and_busy_start();
        int t0, dn0, ac0, n;
        logic [31:0] e_ld; logic e_err; int e_lat;
        poke(6'd63, 8'hFF); poke(6'd0, 8'h7F);
        dn0 = dn_data_q.size(); ac0 = acc_addr_q.size();
        exp_ld_q.push_back(32'h0000_7FFF); exp_err_q.push_back(1'b0); exp_lat_q.push_back(3);
        issue(1'b0, 3'b001, 32'hFFFF_FFFF, 32'h0, t0);
        // Start held through both ACCESS cycles and the DONE cycle
        start = 1'b1; funct3 = 3'b010; base_address = 32'h0000_1000;
        repeat (3) begin
            @(negedge clk); #1;
        end
        start = 1'b0;
        repeat (6) @(negedge clk);
        tests_run++;
        n = acc_addr_q.size() - ac0;
        if (n != 2 || acc_addr_q[ac0] !== 32'hFFFF_FFFF || acc_addr_q[ac0 + 1] !== 32'h0000_0000) begin
            tests_failed++;
            $display("FAIL wrap_addr: %0d access cycles, first %h, required 2: FFFFFFFF then 00000000",
                     n, (n > 0) ? acc_addr_q[ac0] : 32'h0);
        end
        tests_run++;
        if (dn_data_q.size() != dn0 + 1 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL busy_start_ignored: %0d done pulses busy=%b, required 1 pulse busy=0", dn_data_q.size() - dn0, busy);
        end
        tests_run++;
        e_ld = exp_ld_q.pop_front(); e_err = exp_err_q.pop_front(); e_lat = exp_lat_q.pop_front();
        if (dn_data_q.size() < dn0 + 1) begin
            tests_failed++;
            $display("FAIL wrap_result: no done pulse, required ld=%h", e_ld);
        end else if (dn_data_q[dn0] !== e_ld || dn_err_q[dn0] !== e_err || dn_cyc_q[dn0] - t0 != e_lat) begin
            tests_failed++;
            $display("FAIL wrap_result: ld=%h err=%b lat=%0d, required ld=%h err=%b lat=%0d",
                     dn_data_q[dn0], dn_err_q[dn0], dn_cyc_q[dn0] - t0, e_ld, e_err, e_lat);
        end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_lb_lbu();
        test_sh_readback();
        test_illegal();
        test_reset_mid_sw();
        test_wrap_and_busy_start();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Initiator side of the byte-wide memory bus. It turns one 32-bit-capable RISC-V load or store request (LB/LH/LW/LBU/LHU/SB/SH/SW) into a sequence of single-byte accesses on the `memory_synth` ROM/RAM port, assembling little-endian load results and sign or zero extending them. It sits between the CPU execute stage and the memory subsystem. Misaligned addresses are legal because every access is byte-granular.

## Interface
- Parameters: none.
- `clk` in 1: single clock; all state updates on rising edge.
- `reset_n` in 1: synchronous, active-low reset.
- `start` in 1: request strobe; sampled only in IDLE.
- `is_store` in 1: 1 = store, 0 = load.
- `funct3` in 3: RISC-V width code. 000 = B, 001 = H, 010 = W, 100 = BU, 101 = HU (BU/HU are loads only).
- `base_address` in 32: byte address of the request.
- `store_data` in 32: store source; the low bytes are used.
- `busy` out 1: high in ACCESS and DONE.
- `done` out 1: one-cycle completion pulse.
- `error` out 1: valid while `done` is high; marks an illegal request.
- `load_data` out 32: extended load result; held until the next accepted request.
- `mem_address` out 32: byte address to memory.
- `mem_write_data` out 8: byte to write.
- `mem_write_enable` out 1: memory write strobe; the memory commits it on the rising edge.
- `mem_read_data` in 8: combinational read data from memory for `mem_address`.

## Operation
- State machine: IDLE -> ACCESS -> DONE -> IDLE.
- **IDLE, `start` = 1:**
  - Latch `base_address`, `store_data`, `is_store` and `funct3`.
  - Clear the byte index `idx`.
  - Clear the load buffer.
  - Go to ACCESS. If the request is illegal, go straight to DONE with the error flag set.
- **Illegal requests:** `funct3` in {011, 110, 111}, or a store with `funct3[2]` = 1.
- **Byte count N:** 1 for B/BU, 2 for H/HU, 4 for W.
- **ACCESS, one byte per cycle:**
  - `mem_address` = latched address + `idx`, computed modulo 2^32 (0xFFFFFFFF + 1 wraps to 0x00000000).
  - Load: capture `mem_read_data` into buffer byte `idx` at the clock edge.
  - Store: `mem_write_data` = latched `store_data[8*idx+7 : 8*idx]`.
  - `idx` increments each cycle. After byte N-1, go to DONE.
- **DONE, exactly one cycle:**
  - `done` = 1.
  - `load_data` is updated from the buffer:
    - B: sign-extend bit 7.
    - BU: zero-extend from bit 7.
    - H: sign-extend bit 15.
    - HU: zero-extend from bit 15.
    - W: pass through unchanged.
  - Store, or illegal request: `load_data` = 0.
  - Go to IDLE.
- **Write strobe:** `mem_write_enable` = `reset_n` AND (state == ACCESS) AND latched `is_store` AND no error. It is the only output that depends combinationally on an input, so no byte is ever committed in a cycle where `reset_n` = 0.
- **Memory outputs outside ACCESS:** `mem_address` = latched address; `mem_write_data` = 0.
- **`start` while busy:** ignored, with no queueing. A `start` in the DONE cycle is also ignored.
- **Reset (synchronous):** forces IDLE; `idx`, latched address, latched data, `load_data`, `done`, `error` and `busy` all go to 0.
- **Reset mid-operation:** bytes already written stay written, no further bytes are written, and no `done` pulse is produced.

## Timing
- Request accepted at edge E0.
- ACCESS occupies cycles 1..N.
- `done` is high in cycle N+1 (latency N+1 cycles from the accepting edge).
- `busy` falls at the edge that ends DONE.
- Back-to-back throughput: a new `start` is accepted in the cycle after DONE, giving N+2 cycles per request.
- Illegal request: `done` = 1 and `error` = 1 in cycle 1; `mem_write_enable` never asserts.
- `load_data` changes only at the edge entering DONE or on reset.

## Test plan
- **LW** at 0x00001000, memory bytes 78 56 34 12:
  - Addresses 0x1000..0x1003 presented in cycles 1–4.
  - `done` in cycle 5.
  - `load_data` = 0x12345678, `error` = 0.
- **LB / LBU** at 0x00001003, byte 0x80:
  - LB gives `load_data` = 0xFFFFFF80.
  - LBU gives 0x00000080.
  - Each has `done` in cycle 2.
- **SH** at 0x00001001, `store_data` = 0xAABBCCDD:
  - `mem_write_enable` high in exactly 2 cycles, writing 0xDD to 0x1001 and then 0xCC to 0x1002.
  - Readback with LHU gives 0x0000CCDD.
- **Illegal requests** (`funct3` = 011 load, and `funct3` = 100 store):
  - `done` and `error` both 1 in cycle 1.
  - Zero write cycles.
  - `load_data` = 0.
- **Reset mid-SW** at 0x00001000 with `store_data` = 0x11223344, `reset_n` low during the third ACCESS cycle:
  - Only 0x44 and 0x33 are written.
  - No `done` pulse; all outputs are 0 after the edge.
  - A following LW request completes normally.
- **Wrap-around** LH at 0xFFFFFFFF:
  - Addresses 0xFFFFFFFF, then 0x00000000.
  - Bytes 0xFF and 0x7F give `load_data` = 0x00007FFF.
  - `start` pulses during `busy` are ignored.
